// File: rtl/cfa_scan_ctrl_if.sv
// Pixel handshake plus the strobes and position that steer the bayer colour lookup.
// slave is the scan controller; master is the upstream source / bayer consumer side.
interface cfa_scan_ctrl_if #(
  parameter int DIM_W = 12
) ();
  logic             pix_valid;
  logic             pix_ready;
  logic             start;
  logic             rowUpdate;
  logic             colUpdate;
  logic [1:0]       patternSelect;
  logic [DIM_W-1:0] col_cnt;
  logic [DIM_W-1:0] row_cnt;
  logic             sof;
  logic             eol;
  logic             eof;

  modport slave (
    input  pix_valid,
    output pix_ready, start, rowUpdate, colUpdate, patternSelect,
           col_cnt, row_cnt, sof, eol, eof
  );

  modport master (
    output pix_valid,
    input  pix_ready, start, rowUpdate, colUpdate, patternSelect,
           col_cnt, row_cnt, sof, eol, eof
  );
endinterface

// File: rtl/cfa_scan_ctrl.sv
// Raster-scan sequencer: counts row/column of accepted pixels and strobes the bayer
// lookup so its colour symbol tracks the pixel; bayer line parity is left at 0 per frame.
module cfa_scan_ctrl #(
  parameter int DIM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic [1:0]       cfg_pattern,
  input  logic             frame_go,
  input  logic             abort,
  cfa_scan_ctrl_if.slave   scan,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DONE} state_t;

  state_t           state;
  logic [DIM_W-1:0] w_r, h_r, col_r, row_r;
  logic [1:0]       pat_r;
  logic             par_r;
  logic             cfg_err_r;
  logic             ready, acc, last_col, last_row;

  assign last_col = (col_r == w_r - DIM_W'(1));
  assign last_row = (row_r == h_r - DIM_W'(1));
  // abort blocks acceptance in the same cycle it is seen
  assign ready    = (state == RUN) && !abort;
  assign acc      = scan.pix_valid && ready;

  assign scan.pix_ready     = ready;
  assign scan.start         = (state == LOAD);
  assign scan.colUpdate     = acc && !last_col;
  assign scan.rowUpdate     = (acc && last_col) || (state == FLUSH);
  assign scan.sof           = acc && (col_r == '0) && (row_r == '0);
  assign scan.eol           = acc && last_col;
  assign scan.eof           = acc && last_col && last_row;
  assign scan.patternSelect = pat_r;
  assign scan.col_cnt       = col_r;
  assign scan.row_cnt       = row_r;

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign cfg_err = cfg_err_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      w_r       <= '0;
      h_r       <= '0;
      pat_r     <= 2'b00;
      col_r     <= '0;
      row_r     <= '0;
      par_r     <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_go) begin
            if (cfg_width < DIM_W'(2) || cfg_height == '0) begin
              cfg_err_r <= 1'b1;
            end else begin
              w_r   <= cfg_width;
              h_r   <= cfg_height;
              pat_r <= cfg_pattern;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          col_r <= '0;
          row_r <= '0;
          par_r <= 1'b0;
          state <= abort ? DONE : RUN;
        end
        RUN: begin
          // par_r tracks rowUpdates issued, so an abort knows whether bayer needs a FLUSH
          if (abort) begin
            state <= par_r ? FLUSH : DONE;
          end else if (acc) begin
            if (last_col) begin
              col_r <= '0;
              par_r <= ~par_r;
              if (last_row) begin
                row_r <= '0;
                state <= h_r[0] ? FLUSH : DONE;
              end else begin
                row_r <= row_r + DIM_W'(1);
              end
            end else begin
              col_r <= col_r + DIM_W'(1);
            end
          end
        end
        FLUSH: begin
          par_r <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          col_r <= '0;
          row_r <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfa_scan_ctrl.sv
// Bench for cfa_scan_ctrl: a bayer tracker follows the strobes and each accepted pixel's
// symbol is compared with the colour expected from its raster index.
module tb_cfa_scan_ctrl;
  localparam int DIM_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [DIM_W-1:0] cfg_width = '0;
  logic [DIM_W-1:0] cfg_height = '0;
  logic [1:0]       cfg_pattern = 2'b00;
  logic             frame_go = 1'b0;
  logic             abort = 1'b0;
  logic             busy, done, cfg_err;
  int               checks = 0;
  int               errors = 0;
  logic             lsel, csel;

  always #5 clk = ~clk;

  cfa_scan_ctrl_if #(.DIM_W(DIM_W)) bus ();

  cfa_scan_ctrl #(.DIM_W(DIM_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_pattern(cfg_pattern),
    .frame_go   (frame_go),
    .abort      (abort),
    .scan       (bus.slave),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  // Downstream bayer block: start rewinds the column, rowUpdate flips the line.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      lsel <= 1'b0;
      csel <= 1'b0;
    end else if (bus.start) begin
      csel <= 1'b0;
    end else if (bus.rowUpdate) begin
      lsel <= ~lsel;
      csel <= 1'b0;
    end else if (bus.colUpdate) begin
      csel <= ~csel;
    end
  end

  // Colour code R=0 G=1 B=2 for a pattern at (line parity, column parity).
  function automatic logic [1:0] sym(input logic [1:0] pat, input logic l, input logic c);
    logic [7:0] t;
    int idx;
    case (pat)
      2'd0:    t = {2'd2, 2'd1, 2'd1, 2'd0};
      2'd1:    t = {2'd1, 2'd0, 2'd2, 2'd1};
      2'd2:    t = {2'd1, 2'd2, 2'd0, 2'd1};
      default: t = {2'd0, 2'd1, 2'd1, 2'd2};
    endcase
    idx = {30'd0, l, c};
    return t[idx*2 +: 2];
  endfunction

  task automatic run_frame(input int w, input int h, input logic [1:0] pat,
                           input int vpct, input int abort_at, input int gopct);
    int k = 0;
    int cyc = 0;
    int r, c, flush;
    logic aborted = 1'b0;
    logic acc;
    logic [7:0] exp;
    @(negedge clk);
    cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); cfg_pattern = pat;
    frame_go = 1'b1; abort = 1'b0; bus.pix_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL go_idle: busy=%b required 0", busy); end
    @(negedge clk);
    frame_go = 1'b0;
    #1;
    checks++;
    if ({bus.start, busy, bus.pix_ready, lsel} !== 4'b1100)
      begin errors++; $display("FAIL load: start,busy,ready,lsel=%b required 1100", {bus.start, busy, bus.pix_ready, lsel}); end
    while (k < w*h && !aborted) begin
      @(negedge clk);
      bus.pix_valid = ($urandom_range(99) < vpct);
      abort = (k == abort_at);
      frame_go = ($urandom_range(99) < gopct);
      cfg_pattern = 2'($urandom);
      cfg_width = DIM_W'($urandom_range(1, 20));
      #1;
      cyc++;
      r = k / w;
      c = k % w;
      checks++;
      if ({bus.col_cnt, bus.row_cnt, bus.patternSelect} !== {DIM_W'(c), DIM_W'(r), pat})
        begin errors++; $display("FAIL pos: col=%0d row=%0d pat=%0d required %0d %0d %0d", bus.col_cnt, bus.row_cnt, bus.patternSelect, c, r, pat); end
      if (abort) begin
        aborted = 1'b1;
        checks++;
        if ({bus.pix_ready, bus.colUpdate, bus.rowUpdate, bus.eol, bus.eof} !== 5'b0)
          begin errors++; $display("FAIL abort_cycle: ready,col,row,eol,eof=%b required 00000", {bus.pix_ready, bus.colUpdate, bus.rowUpdate, bus.eol, bus.eof}); end
      end else begin
        acc = bus.pix_valid;
        exp = {1'b1, acc && c != w-1, acc && c == w-1, acc && k == 0,
               acc && c == w-1, acc && k == w*h-1, 1'b0, 1'b0};
        checks++;
        if ({bus.pix_ready, bus.colUpdate, bus.rowUpdate, bus.sof, bus.eol, bus.eof, cfg_err, done} !== exp)
          begin errors++; $display("FAIL run k=%0d: rdy,cu,ru,sof,eol,eof,err,done=%b required %b", k, {bus.pix_ready, bus.colUpdate, bus.rowUpdate, bus.sof, bus.eol, bus.eof, cfg_err, done}, exp); end
        if (acc) begin
          checks++;
          if (sym(pat, lsel, csel) !== sym(pat, r[0], c[0]))
            begin errors++; $display("FAIL symbol k=%0d: got %0d required %0d", k, sym(pat, lsel, csel), sym(pat, r[0], c[0])); end
          k++;
        end
      end
      if (cyc > 5000) begin
        checks++; errors++;
        $display("FAIL timeout: accepted %0d required %0d", k, w*h);
        break;
      end
    end
    flush = aborted ? (k / w) % 2 : h % 2;
    @(negedge clk);
    frame_go = 1'b0; abort = 1'b0; bus.pix_valid = 1'b1;
    #1;
    checks++;
    if ({bus.pix_ready, bus.rowUpdate, done} !== {1'b0, flush[0], ~flush[0]})
      begin errors++; $display("FAIL tail: ready,rowUpdate,done=%b required %b", {bus.pix_ready, bus.rowUpdate, done}, {1'b0, flush[0], ~flush[0]}); end
    if (flush != 0) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus.pix_ready, bus.rowUpdate, done} !== 3'b001)
        begin errors++; $display("FAIL flush_done: ready,rowUpdate,done=%b required 001", {bus.pix_ready, bus.rowUpdate, done}); end
    end
    checks++;
    if ({lsel, busy} !== 2'b01)
      begin errors++; $display("FAIL parity_at_done: lsel,busy=%b required 01", {lsel, busy}); end
    @(negedge clk);
    bus.pix_valid = 1'b0;
    #1;
    checks++;
    if ({busy, done, bus.col_cnt, bus.row_cnt} !== '0)
      begin errors++; $display("FAIL idle_after: busy=%b done=%b col=%0d row=%0d required 0", busy, done, bus.col_cnt, bus.row_cnt); end
  endtask

  task automatic test_reset();
    bus.pix_valid = 1'b1;
    frame_go = 1'b1;
    cfg_width = 12'd4; cfg_height = 12'd2;
    #12;
    checks++;
    if ({busy, done, cfg_err, bus.pix_ready, bus.start, bus.rowUpdate, bus.colUpdate,
         bus.sof, bus.eol, bus.eof, bus.patternSelect, bus.col_cnt, bus.row_cnt} !== '0)
      begin errors++; $display("FAIL reset: busy=%b ready=%b start=%b pat=%0d col=%0d row=%0d required all 0", busy, bus.pix_ready, bus.start, bus.patternSelect, bus.col_cnt, bus.row_cnt); end
    @(negedge clk);
    rst = 1'b1; frame_go = 1'b0; bus.pix_valid = 1'b0;
  endtask

  task automatic test_cfg_err();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cfg_width = (i == 0) ? 12'd1 : 12'd5;
      cfg_height = (i == 0) ? 12'd4 : 12'd0;
      frame_go = 1'b1;
      @(negedge clk);
      frame_go = 1'b0;
      #1;
      checks++;
      if ({cfg_err, busy, bus.start} !== 3'b100)
        begin errors++; $display("FAIL cfg_err_%0d: cfg_err,busy,start=%b required 100", i, {cfg_err, busy, bus.start}); end
      @(negedge clk);
      #1;
      checks++;
      if ({cfg_err, busy} !== 2'b00)
        begin errors++; $display("FAIL cfg_err_pulse_%0d: cfg_err,busy=%b required 00", i, {cfg_err, busy}); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    cfg_width = 12'd4; cfg_height = 12'd2; cfg_pattern = 2'd3; frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0; bus.pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({busy, bus.pix_ready} !== 2'b11)
      begin errors++; $display("FAIL pre_reset: busy,ready=%b required 11", {busy, bus.pix_ready}); end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, cfg_err, bus.pix_ready, bus.start, bus.rowUpdate, bus.colUpdate,
         bus.sof, bus.eol, bus.eof, bus.patternSelect, bus.col_cnt, bus.row_cnt, lsel} !== '0)
      begin errors++; $display("FAIL async_reset: busy=%b ready=%b cu=%b pat=%0d col=%0d row=%0d required all 0", busy, bus.pix_ready, bus.colUpdate, bus.patternSelect, bus.col_cnt, bus.row_cnt); end
    @(negedge clk);
    rst = 1'b1; bus.pix_valid = 1'b0;
    run_frame(4, 2, 2'd0, 100, -1, 0);
  endtask

  task automatic test_random_frames();
    int w, h;
    for (int i = 0; i < 10; i++) begin
      w = $urandom_range(2, 9);
      h = $urandom_range(1, 5);
      run_frame(w, h, 2'($urandom), $urandom_range(30, 100),
                ($urandom_range(3) == 0) ? $urandom_range(0, w*h-1) : -1, 20);
    end
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    test_reset();
    test_cfg_err();
    run_frame(4, 2, 2'd0, 100, -1, 0);
    run_frame(2, 3, 2'd2, 100, -1, 0);
    run_frame(2, 2, 2'd2, 100, -1, 0);
    run_frame(3, 1, 2'd1, 50, -1, 0);
    run_frame(4, 2, 2'd0, 100, 5, 0);
    run_frame(5, 3, 2'd3, 70, -1, 40);
    test_random_frames();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
